// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// serial line levels and the default data width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam int   UART_D_WIDTH     = 4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input line. Both flops reset to the
// idle level so a reset never looks like a start bit.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    // Two-stage resynchronisation of the asynchronous line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= UART_IDLE_LEVEL;
            sync_p1 <= UART_IDLE_LEVEL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/uart_receive.sv
// UART receiver: start bit, D_WIDTH data bits LSB first, one stop bit.
// A good frame updates rx_data with a one-cycle rx_valid pulse; a low stop
// bit gives a one-cycle rx_err pulse and the receiver then waits for the
// line to return high before looking for another start bit.
// Build option: define UART_RX_SYNC_EN to put a 2-flop synchronizer in
// front of the FSM (adds exactly 2 clks to every event). Without it rx is
// used directly, which suits a same-clock source such as uart_transmit.
module uart_receive
    import uart_pkg::*;
#(
    parameter int D_WIDTH      = UART_D_WIDTH,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               rx_err
);

    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(D_WIDTH + 1);
    localparam int HALF = CLKS_PER_BIT / 2;

    // Terminal counts: last clk of a bit period, last clk of the half-bit
    // wait in START, and index of the last data bit.
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [BW-1:0] BIT_LAST      = BW'(D_WIDTH - 1);

    logic               rx_s;
    rx_state_t          state_q, state_d;
    logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [D_WIDTH-1:0] shift_q, shift_d, shift_in;
    logic [D_WIDTH-1:0] rx_data_d;
    logic               rx_valid_d, rx_busy_d, rx_err_d;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    // New sample enters at the MSB so the first (LSB) bit ends up at bit 0
    if (D_WIDTH == 1) begin : g_shift_one
        assign shift_in = rx_s;
    end else begin : g_shift_many
        assign shift_in = {rx_s, shift_q[D_WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counters, shift register and output pulses
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        rx_busy_d  = rx_busy;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (rx_s == UART_START_LEVEL) begin
                    rx_busy_d = 1'b1;
                    shift_d   = '0;
                    // With one clk per bit the detect sample is already mid-bit
                    if (HALF == 0) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                if (clk_cnt_q == CNT_HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s == UART_IDLE_LEVEL) begin
                        state_d   = IDLE;
                        rx_busy_d = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt_q == CNT_BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_in;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (clk_cnt_q == CNT_BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s == UART_IDLE_LEVEL) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        rx_busy_d  = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        rx_err_d = 1'b1;
                        state_d  = WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            WAIT_IDLE: begin
                clk_cnt_d = '0;
                // A held-low (break) line must not be taken as a new start bit
                if (rx_s == UART_IDLE_LEVEL) begin
                    rx_busy_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                rx_busy_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset discards any partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            rx_busy   <= rx_busy_d;
            rx_err    <= rx_err_d;
        end
    end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: one receiver at 1 clk/bit and one at 8 clks/bit.
// A frame-level model predicts rx_data/rx_valid/rx_busy/rx_err from the
// line history and is compared every cycle; directed sequences pin the
// model with literal expectations.
module tb_uart_receive;

    localparam int DW = 4;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rx1, rx8;
    logic [DW-1:0] data1, data8;
    logic          valid1, busy1, err1;
    logic          valid8, busy8, err8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_receive #(.D_WIDTH(DW), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx1),
        .rx_data(data1), .rx_valid(valid1), .rx_busy(busy1), .rx_err(err1)
    );

    uart_receive #(.D_WIDTH(DW), .CLKS_PER_BIT(8)) u_dut8 (
        .clk(clk), .rst(rst), .rx(rx8),
        .rx_data(data8), .rx_valid(valid8), .rx_busy(busy8), .rx_err(err8)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int cpb_of(input int id);
        return (id == 0) ? 1 : 8;
    endfunction

    // ---------------- frame-level reference model ----------------
    // mode 0: idle, 1: inside a frame that started at edge m_t0, 2: waiting for line high
    int            m_mode [2];
    int            m_t0   [2];
    logic [DW-1:0] m_word [2];
    logic [DW-1:0] exp_data [2];
    bit            exp_valid [2];
    bit            exp_busy  [2];
    bit            exp_err   [2];
    bit            dly [2][2];
    int            edge_n = 0;
    logic [DW-1:0] got1 [$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_t0[i] = 0; m_word[i] = '0; exp_data[i] = '0;
            exp_valid[i] = 0; exp_busy[i] = 0; exp_err[i] = 0;
            dly[i][0] = 1'b1; dly[i][1] = 1'b1;
        end
    endtask

    // Line value the receiver acts on at this edge (optionally delayed)
    task automatic line_at(input int id, input bit cur, output bit l);
        if (LAT == 0) begin
            l = cur;
        end else begin
            l = dly[id][1];
            dly[id][1] = dly[id][0];
            dly[id][0] = cur;
        end
    endtask

    // Start confirm at t0+H, data bit k-1 at t0+H+k*CPB, stop at t0+H+(DW+1)*CPB
    task automatic model_step(input int id, input bit l);
        int cpb, h, off, k;
        cpb = cpb_of(id);
        h   = cpb / 2;
        exp_valid[id] = 0;
        exp_err[id]   = 0;
        if (m_mode[id] == 0) begin
            if (!l) begin
                m_mode[id] = 1; m_t0[id] = edge_n; exp_busy[id] = 1;
            end
        end else if (m_mode[id] == 1) begin
            off = edge_n - m_t0[id];
            if (h > 0 && off == h) begin
                if (l) begin m_mode[id] = 0; exp_busy[id] = 0; end
            end else if (off > h && ((off - h) % cpb) == 0) begin
                k = (off - h) / cpb;
                if (k <= DW) begin
                    m_word[id][k-1] = l;
                end else if (l) begin
                    exp_data[id] = m_word[id]; exp_valid[id] = 1;
                    m_mode[id] = 0; exp_busy[id] = 0;
                end else begin
                    exp_err[id] = 1; m_mode[id] = 2;
                end
            end
        end else begin
            if (l) begin m_mode[id] = 0; exp_busy[id] = 0; end
        end
    endtask

    task automatic compare(input int id, input logic [DW-1:0] d, input logic v,
                           input logic b, input logic e);
        string p;
        p = (id == 0) ? "cpb1" : "cpb8";
        check({p, " rx_data"},  int'(d), int'(exp_data[id]));
        check({p, " rx_valid"}, int'(v), int'(exp_valid[id]));
        check({p, " rx_busy"},  int'(b), int'(exp_busy[id]));
        check({p, " rx_err"},   int'(e), int'(exp_err[id]));
    endtask

    // Per-cycle model update and comparison, one tick after each active edge
    always begin
        bit l0, l1;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            edge_n++;
            line_at(0, rx1, l0);
            line_at(1, rx8, l1);
            model_step(0, l0);
            model_step(1, l1);
            if (valid1) got1.push_back(data1);
        end
        compare(0, data1, valid1, busy1, err1);
        compare(1, data8, valid8, busy8, err8);
    end

    // ---------------- stimulus helpers ----------------
    bit q1 [$];
    bit q8 [$];

    task automatic push_bits(input int id, input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            if (id == 0) q1.push_back(b); else q8.push_back(b);
        end
    endtask

    task automatic push_frame(input int id, input logic [DW-1:0] d, input bit stop, input int gap);
        int cpb;
        cpb = cpb_of(id);
        push_bits(id, 1'b0, cpb);
        for (int i = 0; i < DW; i++) push_bits(id, d[i], cpb);
        push_bits(id, stop, cpb);
        push_bits(id, 1'b1, gap);
    endtask

    task automatic send1(input logic [DW-1:0] d, input bit stop);
        @(negedge clk) rx1 = 1'b0;
        for (int i = 0; i < DW; i++) @(negedge clk) rx1 = d[i];
        @(negedge clk) rx1 = stop;
    endtask

    initial begin
        bit t1 [8];
        bit t3 [6];
        int r, nfr, g0, g1;

        t1 = '{1, 1, 0, 1, 0, 1, 1, 1};
        t3 = '{0, 1, 1, 1, 1, 0};
        rst = 1'b1; rx1 = 1'b1; rx8 = 1'b1;
        model_reset();
        #1;
        check("reset rx_data", int'(data1), 0);
        check("reset rx_valid", int'(valid1), 0);
        check("reset rx_busy", int'(busy8), 0);
        check("reset rx_err", int'(err8), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Known frame: data 4'hD, valid one clk after the stop-bit sample
        for (int i = 0; i < 8; i++) @(negedge clk) rx1 = t1[i];
        @(posedge clk);
        repeat (LAT) @(posedge clk);
        #1;
        check("t1 rx_valid", int'(valid1), 1);
        check("t1 rx_data", int'(data1), 13);
        check("t1 rx_err", int'(err1), 0);
        check("t1 rx_busy", int'(busy1), 0);

        // Back-to-back frames A then 5 with no idle gap
        repeat (2) @(negedge clk);
        got1.delete();
        send1(4'hA, 1'b1);
        send1(4'h5, 1'b1);
        @(negedge clk) rx1 = 1'b1;
        repeat (6) @(negedge clk);
        check("b2b count", got1.size(), 2);
        g0 = (got1.size() > 0) ? int'(got1[0]) : -1;
        g1 = (got1.size() > 1) ? int'(got1[1]) : -1;
        check("b2b first", g0, 10);
        check("b2b second", g1, 5);

        // Low stop bit: one rx_err pulse, busy held while the line stays low
        for (int i = 0; i < 6; i++) @(negedge clk) rx1 = t3[i];
        @(posedge clk);
        repeat (LAT) @(posedge clk);
        #1;
        check("ferr rx_err", int'(err1), 1);
        check("ferr rx_valid", int'(valid1), 0);
        check("ferr rx_data held", int'(data1), 5);
        repeat (3) @(posedge clk);
        #1;
        check("break rx_busy", int'(busy1), 1);
        check("break rx_err", int'(err1), 0);
        @(negedge clk) rx1 = 1'b1;
        @(posedge clk);
        repeat (LAT) @(posedge clk);
        #1;
        check("break release rx_busy", int'(busy1), 0);

        // 8 clks/bit: 2-clk low glitch is rejected at the half-bit resample
        repeat (3) @(negedge clk);
        @(negedge clk) rx8 = 1'b0;
        @(negedge clk);
        @(negedge clk) rx8 = 1'b1;
        repeat (2 + LAT) @(posedge clk);
        #1;
        check("glitch busy before resample", int'(busy8), 1);
        @(posedge clk);
        #1;
        check("glitch busy after resample", int'(busy8), 0);
        check("glitch rx_valid", int'(valid8), 0);
        check("glitch rx_err", int'(err8), 0);

        // Asynchronous reset in the middle of a data phase
        repeat (3) @(negedge clk);
        @(negedge clk) rx1 = 1'b0;
        @(negedge clk) rx1 = 1'b1;
        @(negedge clk) rx1 = 1'b0;
        @(negedge clk) rx1 = 1'b1;
        @(posedge clk);
        #1;
        check("pre-reset rx_busy", int'(busy1), 1);
        #2;
        rst = 1'b1;
        rx1 = 1'b1;
        #1;
        check("async rst rx_data", int'(data1), 0);
        check("async rst rx_busy", int'(busy1), 0);
        check("async rst rx_valid", int'(valid1), 0);
        check("async rst rx_err", int'(err1), 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        send1(4'h3, 1'b1);
        @(posedge clk);
        repeat (LAT) @(posedge clk);
        #1;
        check("post-reset rx_valid", int'(valid1), 1);
        check("post-reset rx_data", int'(data1), 3);
        repeat (2) @(negedge clk);

        // Randomized traffic on both receivers, checked by the model every cycle
        for (int id = 0; id < 2; id++) begin
            nfr = (id == 0) ? 80 : 20;
            for (int f = 0; f < nfr; f++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    push_frame(id, DW'($urandom), 1'b0, 0);
                    push_bits(id, 1'b0, $urandom_range(0, 10));
                    push_bits(id, 1'b1, $urandom_range(1, 4));
                end else if (r == 1) begin
                    push_bits(id, 1'b0, $urandom_range(1, 6));
                    push_bits(id, 1'b1, $urandom_range(1, 12));
                end else begin
                    push_frame(id, DW'($urandom), 1'b1, $urandom_range(0, 3));
                end
            end
        end
        while (q1.size() > 0 || q8.size() > 0) begin
            @(negedge clk);
            rx1 = (q1.size() > 0) ? q1.pop_front() : 1'b1;
            rx8 = (q8.size() > 0) ? q8.pop_front() : 1'b1;
        end
        @(negedge clk);
        rx1 = 1'b1;
        rx8 = 1'b1;
        repeat (120) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
